// File: rtl/scan_pkg.sv
// Shared types and widths for the scan select sequencer.
package scan_pkg;
  localparam int SEL_W  = 3;
  localparam int MASK_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BLANK  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;
endpackage

// File: rtl/scan_next_idx.sv
// Round-robin successor search over the enabled decoder lines.
module scan_next_idx
  import scan_pkg::*;
(
  input  logic [SEL_W-1:0]  cur,
  input  logic [MASK_W-1:0] mask,
  input  logic [3:0]        n_sel,
  output logic [SEL_W-1:0]  nxt,
  output logic              wrap,
  output logic              any
);
  logic [MASK_W-1:0] eff;
  logic [SEL_W-1:0]  lo, hi;
  logic              hi_found;

  // Descending scan so the last hit is the lowest qualifying index.
  always_comb begin
    eff      = '0;
    lo       = '0;
    hi       = '0;
    hi_found = 1'b0;
    for (int i = 0; i < MASK_W; i++)
      eff[i] = mask[i] && (i < int'(n_sel));
    for (int i = MASK_W-1; i >= 0; i--) begin
      if (eff[i]) begin
        lo = SEL_W'(i);
        if (i > int'(cur)) begin
          hi       = SEL_W'(i);
          hi_found = 1'b1;
        end
      end
    end
  end

  assign any  = |eff;
  assign wrap = !hi_found;
  assign nxt  = hi_found ? hi : lo;
endmodule

// File: rtl/scan_select_sequencer.sv
// Drives a 3-to-8 decoder: round-robin over unmasked lines with dwell and
// break-before-make blanking between lines.
module scan_select_sequencer
  import scan_pkg::*;
#(
  parameter int N_SEL = 8,
  parameter int DWELL = 4,
  parameter int BLANK = 2,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [MASK_W-1:0] mask,
  output logic [SEL_W-1:0]  sel,
  output logic              en_n,
  output logic              busy,
  output logic              frame_done
);
  localparam logic [3:0]       NSEL_V  = 4'(N_SEL);
  localparam logic [CNT_W-1:0] DWELL_C = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [SEL_W-1:0]  pending;
  logic [SEL_W-1:0]  cur, nxt;
  logic              wrap, any;

  // From IDLE, searching past index 7 always wraps to the lowest enabled line.
  assign cur = (state == ST_ACTIVE) ? sel : SEL_W'(7);

  scan_next_idx u_next (
    .cur   (cur),
    .mask  (mask),
    .n_sel (NSEL_V),
    .nxt   (nxt),
    .wrap  (wrap),
    .any   (any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      sel        <= '0;
      en_n       <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cnt        <= '0;
      pending    <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run && any) begin
            state   <= ST_BLANK;
            busy    <= 1'b1;
            pending <= nxt;
            cnt     <= BLANK_C;
          end
        end
        ST_BLANK: begin
          if (!run) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            // pending is stable through BLANK, so only the first load changes sel
            sel <= pending;
            if (cnt == '0) begin
              state <= ST_ACTIVE;
              en_n  <= 1'b0;
              cnt   <= DWELL_C;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          if (cnt == '0) begin
            en_n <= 1'b1;
            if (!run || !any) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state      <= ST_BLANK;
              pending    <= nxt;
              cnt        <= BLANK_C;
              frame_done <= wrap;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          en_n  <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_scan_select_sequencer.sv
// Randomized bench with a line-timeline reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_scan_select_sequencer;
  localparam int N_SEL = 8;
  localparam int DWELL = 4;
  localparam int BLANK = 2;
  localparam int CNT_W = 8;
  localparam int PER   = DWELL + BLANK;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [7:0] mask = 8'hFF;
  logic [2:0] sel;
  logic       en_n, busy, frame_done;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int fd_cnt = 0;

  scan_select_sequencer #(.N_SEL(N_SEL), .DWELL(DWELL), .BLANK(BLANK), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run), .mask(mask),
    .sel(sel), .en_n(en_n), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a line is a PER-cycle timeline, pos 0..BLANK-1 blanking,
  // BLANK..PER-1 dwelling; the line target is chosen by modular search.
  logic [7:0] eff_lim;
  assign eff_lim = 8'((9'd1 << N_SEL) - 9'd1);

  function automatic int lowest(input logic [7:0] e);
    for (int j = 0; j < 8; j++) if (e[j]) return j;
    return 0;
  endfunction

  function automatic int rr_next(input int i, input logic [7:0] e);
    for (int j = 1; j <= 8; j++) if (e[(i + j) % 8]) return (i + j) % 8;
    return i;
  endfunction

  bit m_busy, m_fd;
  int m_sel, m_line, m_pos;

  always @(posedge clk or posedge rst) begin : model
    logic [7:0] e;
    int n;
    if (rst) begin
      m_busy <= 0; m_fd <= 0; m_sel <= 0; m_line <= 0; m_pos <= 0;
    end else begin
      e = mask & eff_lim;
      m_fd <= 0;
      if (!m_busy) begin
        if (run && e != 0) begin
          m_busy <= 1; m_line <= lowest(e); m_pos <= 0;
        end
      end else if (m_pos < BLANK) begin
        if (!run) m_busy <= 0;
        else begin m_sel <= m_line; m_pos <= m_pos + 1; end
      end else if (m_pos == PER - 1) begin
        if (!run || e == 0) m_busy <= 0;
        else begin
          n = rr_next(m_line, e);
          m_fd <= (n <= m_line);
          m_line <= n;
          m_pos <= 0;
        end
      end else begin
        m_pos <= m_pos + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("cycle sel", sel, m_sel);
      check("cycle en_n", en_n, !(m_busy && m_pos >= BLANK));
      check("cycle busy", busy, m_busy);
      check("cycle frame_done", frame_done, m_fd);
    end
  end

  // Waits for the first dwell cycle of a line (en_n seen falling), bounded.
  task automatic wait_fall();
    bit prev;
    prev = en_n;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
      if (prev && !en_n) return;
      prev = en_n;
    end
    check("wait_fall timeout", 0, 1);
  endtask

  initial begin
    int seq_exp [5];
    int lows;
    seq_exp = '{2, 5, 7, 2, 5};

    repeat (3) @(negedge clk);
    rst = 0;
    chk_en = 1;
    check("reset sel", sel, 0);
    check("reset en_n", en_n, 1);
    check("reset busy", busy, 0);
    check("reset frame_done", frame_done, 0);
    repeat (3) @(negedge clk);
    check("idle run=0 busy", busy, 0);

    // Full-mask frame, hand-derived timeline
    run = 1; mask = 8'hFF;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      check("full en_n", en_n, (c % PER >= BLANK) ? 0 : 1);
      check("full sel", sel, (c == 0) ? 0 : ((c - 1) / PER) % 8);
      check("full frame_done", frame_done, (c == 48) ? 1 : 0);
    end

    // Asynchronous reset while line 5 dwells
    begin
      bit hit;
      hit = 0;
      for (int k = 0; k < 100 && !hit; k++) begin
        @(negedge clk);
        if (sel == 5 && !en_n) hit = 1;
      end
      check("find line5 active", hit, 1);
    end
    #2 rst = 1;
    #1;
    check("async rst sel", sel, 0);
    check("async rst en_n", en_n, 1);
    check("async rst busy", busy, 0);
    check("async rst frame_done", frame_done, 0);
    @(negedge clk);
    run = 0; rst = 0;
    repeat (4) @(negedge clk);
    check("post-reset idle", busy, 0);

    // Sparse mask sequence and wrap pulse
    mask = 8'b1010_0100; run = 1;
    wait_fall();
    check("sparse seq0", sel, seq_exp[0]);
    fd_cnt = 0;
    for (int k = 1; k < 5; k++) begin
      wait_fall();
      check("sparse seq", sel, seq_exp[k]);
    end
    check("sparse frame_done count", fd_cnt, 1);

    // Drop run on the 2nd dwell cycle of line 3
    mask = 8'hFF;
    for (int k = 0; k < 16; k++) begin
      wait_fall();
      if (sel == 3) break;
    end
    check("reach line3", sel, 3);
    @(negedge clk);
    run = 0;
    @(negedge clk); check("drop dwell3 en_n", en_n, 0);
    @(negedge clk); check("drop dwell4 en_n", en_n, 0);
    @(negedge clk);
    check("drop end en_n", en_n, 1);
    check("drop end busy", busy, 0);
    check("drop end sel", sel, 3);
    run = 1;
    wait_fall();
    check("restart lowest", sel, 0);

    // Mask cleared mid-dwell: the line finishes, then IDLE
    mask = 8'h00;
    lows = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!en_n) lows++;
    end
    check("mask0 remaining dwell", lows, DWELL - 1);
    check("mask0 busy", busy, 0);
    check("mask0 sel", sel, 0);

    // Single enabled line repeats
    mask = 8'b0001_0000;
    wait_fall();
    for (int k = 0; k < 3 * PER; k++) begin
      check("single sel", sel, 4);
      check("single en_n", en_n, (k % PER < DWELL) ? 0 : 1);
      check("single frame_done", frame_done, (k % PER == DWELL) ? 1 : 0);
      @(negedge clk);
    end

    // Random traffic against the model
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      run = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: mask = 8'h00;
          1: mask = 8'(1 << $urandom_range(0, 7));
          default: mask = 8'($urandom);
        endcase
      end
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1;
        @(negedge clk);
        #2 rst = 0;
      end
    end

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/scan_select_sequencer.md
Name: scan_select_sequencer

Overview:
- Sequential front-end that drives the 3-to-8 decoder built from two 2-to-4 decoders.
- Generates a 3-bit select index plus an active-low enable, stepping round-robin through the decoder outputs that are currently unmasked.
- Each selected line is held for a programmable dwell time, with a break-before-make blanking gap between lines.
- Used for LED/keypad/row scanning; the decoder's active-low one-hot outputs drive the rows.

Parameters:
- N_SEL, 8, number of decoder lines scanned (2..8); mask bits at N_SEL and above are ignored.
- DWELL, 4, cycles en_n is held low per line (1..2^CNT_W).
- BLANK, 2, cycles en_n is held high between lines (2..2^CNT_W; minimum 2 is required for break-before-make).
- CNT_W, 8, width of the shared dwell/blank down-counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- run  in  1  level; 1 = scan, 0 = stop at the next line boundary.
- mask  in  8  per-line scan enable; 1 = line included. Sampled only at line boundaries and in IDLE.
- sel  out  3  decoder select index; wire sel[0]=x, sel[1]=y, sel[2]=bank select.
- en_n  out  1  active-low decoder enable.
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse when the scan wraps back to the lowest enabled line.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any time, including mid-dwell): state=IDLE, sel=0, en_n=1, busy=0, frame_done=0, counter=0.
- States: IDLE, BLANK, ACTIVE. en_n=0 only in ACTIVE.
- next(i): lowest enabled index > i, else lowest enabled index overall (wrap). Wrap means next(i) <= i. Implemented as a round-robin search over mask[N_SEL-1:0].
- IDLE -> BLANK when run=1 and the masked mask is nonzero.
  - On entry: pending index = lowest enabled index, counter=BLANK-1, wrap flag cleared.
  - Otherwise IDLE holds, with sel keeping its last value.
- BLANK:
  - en_n=1.
  - On the first BLANK cycle's closing edge, sel loads the pending index. sel therefore changes exactly 1 cycle after en_n rises and is stable for at least BLANK-1 cycles before en_n falls.
  - Counter decrements each cycle; at 0 -> ACTIVE, counter=DWELL-1, en_n=0 on that edge.
  - If run=0 during BLANK: -> IDLE on the next edge; en_n stays 1.
- ACTIVE:
  - en_n=0 for exactly DWELL cycles.
  - run=0 does not truncate the dwell.
  - At counter=0:
    - If run=0 or the masked mask is zero: -> IDLE, en_n=1, sel held.
    - Otherwise: -> BLANK, en_n=1, pending=next(sel); frame_done=1 for that one cycle if a wrap occurs.
- Single enabled line: next(i)=i, which is a wrap. That line repeats with blanking between dwells, and frame_done pulses at every dwell end.
- mask changes mid-dwell have no effect until the dwell-end edge.
- Steady state: line period = DWELL+BLANK cycles.
- Counter arithmetic is unsigned, CNT_W bits, with no wrap past 0.

Decomposition:
- Package scan_pkg holds:
  - state enum (IDLE, BLANK, ACTIVE), 2 bits;
  - SEL_W=3;
  - MASK_W=8.
- One combinational sub-module, scan_next_idx, with inputs cur[2:0], mask[7:0], n_sel and outputs nxt[2:0], wrap, any.

Test Plan:
- Reset values: assert rst mid-ACTIVE with sel=5 -> immediately sel=0, en_n=1, busy=0, frame_done=0. Deassert rst with run=0 -> stays IDLE.
- Full mask, DWELL=4, BLANK=2, run=1:
  - sel steps 0,1,...,7,0;
  - each en_n low window is exactly 4 cycles, with exactly 2 high cycles between;
  - sel changes exactly 1 cycle after en_n rises;
  - frame_done pulses once, on the edge ending line 7.
- mask=8'b1010_0100: sel sequence 2,5,7,2,5. frame_done only at the 7->2 transition. Lines 0,1,3,4,6 never selected.
- Drop run on the 2nd dwell cycle of line 3:
  - en_n stays low 2 more cycles, then en_n=1 and IDLE, busy=0, sel=3.
  - Reassert run -> restarts at the lowest enabled line.
- Set mask=0 mid-dwell -> the line completes its dwell, then IDLE. With run=1 and mask=0, the block stays IDLE.
- mask=8'b0001_0000 -> sel=4 constant; en_n pattern is 4 low / 2 high repeating; frame_done at every dwell end.
